// File: rtl/spgd_pkg.sv
// spgd_pkg
// Shared definitions for the SPGD perturbation sequencer: the DAC control
// word width, the saturation limits of 14-bit two's complement and the
// sequencer state encoding.
package spgd_pkg;

    localparam int U_W = 14;

    localparam logic [U_W-1:0] U_MAX = 14'h1FFF;   // +8191
    localparam logic [U_W-1:0] U_MIN = 14'h2000;   // -8192

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PLUS    = 3'd1,
        S_WAIT_P  = 3'd2,
        S_MINUS   = 3'd3,
        S_WAIT_M  = 3'd4,
        S_UPDATE  = 3'd5,
        S_RESTORE = 3'd6
    } state_t;

endpackage

// File: rtl/sat_addsub.sv
// sat_addsub
// Combinational saturating add/subtract on U_W-bit two's complement words.
// Ports:
//   a, b     in   U_W  operands
//   sub_sel  in   1    0: a + b, 1: a - b
//   result   out  U_W  clamped result
//   sat      out  1    high when the result was clamped
module sat_addsub
    import spgd_pkg::*;
(
    input  logic [U_W-1:0] a,
    input  logic [U_W-1:0] b,
    input  logic           sub_sel,
    output logic [U_W-1:0] result,
    output logic           sat
);

    logic [U_W:0] a_x;
    logic [U_W:0] b_x;
    logic [U_W:0] sum_x;

    // One guard bit holds the exact result, so overflow shows up as the two
    // top bits disagreeing. This also covers a - 0x2000, whose negated operand
    // is not representable in U_W bits.
    always_comb begin
        a_x   = {a[U_W-1], a};
        b_x   = {b[U_W-1], b};
        sum_x = sub_sel ? (a_x - b_x) : (a_x + b_x);
        sat   = sum_x[U_W] ^ sum_x[U_W-1];
        if (!sat) begin
            result = sum_x[U_W-1:0];
        end else if (sum_x[U_W]) begin
            result = U_MIN;
        end else begin
            result = U_MAX;
        end
    end

endmodule

// File: rtl/spgd_perturb_seq.sv
// spgd_perturb_seq
// Runs one SPGD iteration on the DAC control value U: drives U+delta, takes
// metric Jp, drives U-delta, takes metric Jm, steps U toward the larger
// metric and writes the committed U back to the DAC.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                begin an iteration (accepted only when idle)
//   delta, step          signed perturbation / update step, latched at start
//   metric, metric_valid unsigned metric and its one-cycle qualifier
//   dac_u, dac_valid     registered DAC word and its update strobe
//   u_cur                committed U
//   busy, done           not idle / end-of-iteration pulse
//   sat_flag             sticky clamp indicator, cleared by an accepted start
//   sat_cnt              (only with SPGD_SAT_COUNT_EN) saturating clamp count
//
// States:
//   S_IDLE    | waiting for start; PLUS word is launched on acceptance
//   S_PLUS    | dac_u = sat(U+delta) is presented with dac_valid
//   S_WAIT_P  | waiting for Jp; MINUS word is launched on metric_valid
//   S_MINUS   | dac_u = sat(U-delta) is presented with dac_valid
//   S_WAIT_M  | waiting for Jm
//   S_UPDATE  | compare Jp/Jm, commit the stepped U
//   S_RESTORE | dac_u = committed U with dac_valid and done
//
// DAC words are registered on the transition into the state that presents
// them, so dac_valid is visible in the cycle right after start.
module spgd_perturb_seq
    import spgd_pkg::*;
#(
    parameter int             MET_W  = 16,
    parameter logic [U_W-1:0] U_INIT = 14'h0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [U_W-1:0]   delta,
    input  logic [U_W-1:0]   step,
    input  logic [MET_W-1:0] metric,
    input  logic             metric_valid,
    output logic [U_W-1:0]   dac_u,
    output logic             dac_valid,
    output logic [U_W-1:0]   u_cur,
    output logic             busy,
    output logic             done,
    output logic             sat_flag
`ifdef SPGD_SAT_COUNT_EN
    ,
    output logic [15:0]      sat_cnt
`endif
);

    state_t state;
    state_t state_nxt;

    logic [U_W-1:0]   delta_q;
    logic [U_W-1:0]   step_q;
    logic [MET_W-1:0] jp;
    logic [MET_W-1:0] jm;

    logic             start_acc;
    logic             perturb_load;
    logic             update_load;
    logic [U_W-1:0]   pert_b;
    logic             pert_sub;
    logic [U_W-1:0]   pert_result;
    logic             pert_sat;
    logic             upd_sub;
    logic [U_W-1:0]   upd_result;
    logic             upd_sat;
    logic [U_W-1:0]   u_nxt;
    logic             sat_evt;

    sat_addsub u_pert (
        .a       (u_cur),
        .b       (pert_b),
        .sub_sel (pert_sub),
        .result  (pert_result),
        .sat     (pert_sat)
    );

    sat_addsub u_upd (
        .a       (u_cur),
        .b       (step_q),
        .sub_sel (upd_sub),
        .result  (upd_result),
        .sat     (upd_sat)
    );

    always_comb begin
        state_nxt    = state;
        start_acc    = 1'b0;
        perturb_load = 1'b0;
        update_load  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    start_acc    = 1'b1;
                    perturb_load = 1'b1;
                    state_nxt    = S_PLUS;
                end
            end
            S_PLUS:   state_nxt = S_WAIT_P;
            S_WAIT_P: begin
                if (metric_valid) begin
                    perturb_load = 1'b1;
                    state_nxt    = S_MINUS;
                end
            end
            S_MINUS:  state_nxt = S_WAIT_M;
            S_WAIT_M: begin
                if (metric_valid) begin
                    state_nxt = S_UPDATE;
                end
            end
            S_UPDATE: begin
                update_load = 1'b1;
                state_nxt   = S_RESTORE;
            end
            S_RESTORE: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // The PLUS word is computed from the live delta input in the accept cycle,
    // before delta_q has been loaded.
    always_comb begin
        pert_b   = (state == S_IDLE) ? delta : delta_q;
        pert_sub = (state == S_WAIT_P);
        upd_sub  = (jp < jm);
        u_nxt    = (jp != jm) ? upd_result : u_cur;
        sat_evt  = (perturb_load && pert_sat) ||
                   (update_load && (jp != jm) && upd_sat);
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            u_cur     <= U_INIT;
            dac_u     <= U_INIT;
            dac_valid <= 1'b0;
            done      <= 1'b0;
            sat_flag  <= 1'b0;
            delta_q   <= '0;
            step_q    <= '0;
            jp        <= '0;
            jm        <= '0;
        end else begin
            state     <= state_nxt;
            dac_valid <= perturb_load || update_load;
            done      <= update_load;
            if (start_acc) begin
                delta_q <= delta;
                step_q  <= step;
            end
            if (perturb_load) begin
                dac_u <= pert_result;
            end
            if (state == S_WAIT_P && metric_valid) begin
                jp <= metric;
            end
            if (state == S_WAIT_M && metric_valid) begin
                jm <= metric;
            end
            if (update_load) begin
                u_cur <= u_nxt;
                dac_u <= u_nxt;
            end
            // An accepted start clears the flag, but the PLUS word launched
            // in the same cycle may set it again.
            if (start_acc) begin
                sat_flag <= pert_sat;
            end else if (sat_evt) begin
                sat_flag <= 1'b1;
            end
        end
    end

`ifdef SPGD_SAT_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt <= '0;
        end else if (sat_evt && (sat_cnt != 16'hFFFF)) begin
            sat_cnt <= sat_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/spgd_perturb_seq.md
Name: spgd_perturb_seq

Overview:
- Initiator side of the saturating U±delta add/sub interface. It issues the perturbation requests for one SPGD iteration on a single 14-bit DAC control value U, collects the two metric responses and applies the gradient step.
- Sits between the SPGD controller (start, delta, step) and the DAC write path and metric ADC path.
- All arithmetic uses 14-bit two's complement with saturation. Representable range is 0x2000 (-8192) to 0x1FFF (+8191).

Parameters:
- U_W, 14, width of U, delta, step and DAC word.
- MET_W, 16, width of the unsigned metric.
- U_INIT, 14'h0000, value of U after reset.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin one iteration; honoured only in IDLE.
- delta  in  U_W  signed perturbation amplitude; sampled when start is accepted.
- step  in  U_W  signed update step; sampled when start is accepted.
- metric  in  MET_W  unsigned metric J.
- metric_valid  in  1  metric qualifier, one cycle.
- dac_u  out  U_W  registered value driven to the DAC.
- dac_valid  out  1  one-cycle strobe whenever dac_u updates.
- u_cur  out  U_W  committed U register.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at the end of an iteration.
- sat_flag  out  1  sticky; set by any saturated operation, cleared by an accepted start.

Behaviour:
- Reset values (asynchronous, rst_n=0):
  - state=IDLE.
  - u_cur=U_INIT, dac_u=U_INIT.
  - dac_valid=0, busy=0, done=0, sat_flag=0.
  - Jp=0, Jm=0, latched delta/step=0.
- States: IDLE, PLUS, WAIT_P, MINUS, WAIT_M, UPDATE, RESTORE.
- IDLE: when start=1, latch delta and step, clear sat_flag, go to PLUS. start in any other state is ignored; no queuing.
- PLUS (1 cycle):
  - dac_u <= sat(u_cur + delta), dac_valid=1.
  - Go to WAIT_P.
  - dac_valid is visible on the cycle after start, so latency is 1 cycle.
- WAIT_P: wait for metric_valid=1, then Jp <= metric and go to MINUS. metric_valid is ignored in every other state, including the cycle dac_valid is high.
- MINUS (1 cycle):
  - dac_u <= sat(u_cur - delta), dac_valid=1.
  - Go to WAIT_M.
  - u_cur is unchanged by the perturbation.
- WAIT_M: on metric_valid, Jm <= metric and go to UPDATE.
- UPDATE (1 cycle), unsigned compare of Jp and Jm:
  - Jp > Jm: u_cur <= sat(u_cur + step).
  - Jp < Jm: u_cur <= sat(u_cur - step).
  - Jp == Jm: u_cur is held.
- RESTORE (1 cycle):
  - dac_u <= u_cur, dac_valid=1, done=1.
  - Go to IDLE.
  - start is not accepted in this cycle; the earliest accepted start is the next cycle.
- Arithmetic and saturation:
  - Compute in U_W+1 bits.
  - Overflow is detected when both operands have the same sign (with b negated for subtraction) and the result sign differs.
  - Positive overflow clamps to 0x1FFF; negative overflow clamps to 0x2000.
  - Subtracting delta=0x2000 is an overflow case and clamps accordingly.
  - Any clamp sets sat_flag.
- Boundary cases:
  - No timeout: WAIT states hold indefinitely.
  - rst_n asserted mid-iteration aborts immediately to the reset values; no done pulse.
  - delta=0: two dac_valid strobes carrying the same value; the iteration still completes.

Optional Feature:
- Macro: SPGD_SAT_COUNT_EN.
- Defined:
  - Adds output sat_cnt[15:0], a free-running count of saturated operations.
  - Saturates at 0xFFFF and is reset to 0.
  - It is not cleared by start.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package spgd_pkg holds:
  - U_W.
  - The constants U_MAX=14'h1FFF and U_MIN=14'h2000.
  - The state enum typedef.
- Combinational sub-module sat_addsub (a, b, sub_sel, result, sat) is instantiated twice: once for the perturb path and once for the update path.

Test Plan:
1. U_INIT=0x1FF7, delta=0x0005, step=0x0001; Jp=100, Jm=50 -> dac_u=0x1FFC then 0x1FF2; u_cur=0x1FF8; RESTORE dac_u=0x1FF8; done pulses; sat_flag=0.
2. U_INIT=0x1FFC, delta=0x0005 -> PLUS dac_u=0x1FFF, MINUS dac_u=0x1FF7, sat_flag=1.
3. U_INIT=0x2003, delta=0x0007; Jp=10, Jm=20, step=0x0004 -> MINUS dac_u=0x2000; u_cur=0x2000 (clamped); sat_flag=1.
4. Jp == Jm=0x1234 -> u_cur unchanged; exactly 3 dac_valid strobes and 1 done per iteration.
5. start pulsed during WAIT_P, and metric_valid on the same cycle as PLUS dac_valid -> both ignored; the FSM advances only on a later metric_valid.
6. rst_n low during WAIT_M -> all outputs return to reset values asynchronously; no done; a new start after release completes a normal iteration.
